// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch/handshake bundle between the PC sequencer and the
// rest of the core (instruction ROM, register-file compare, I/O port).
// The master modport is the sequencer itself; slave is the surrounding core.
interface pc_sequencer_if #(
  parameter int PC_W = 11
);
  logic [31:0]     inst;
  logic            eq;
  logic            in_valid;
  logic            out_ready;
  logic [PC_W-1:0] pc;
  logic            commit;
  logic            in_ready;
  logic            out_valid;
  logic            halted;
  logic [15:0]     retire_cnt;

  modport master (
    input  inst, eq, in_valid, out_ready,
    output pc, commit, in_ready, out_valid, halted, retire_cnt
  );

  modport slave (
    output inst, eq, in_valid, out_ready,
    input  pc, commit, in_ready, out_valid, halted, retire_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch sequencing for the single-cycle
// core. Chooses sequential / branch / jump / halt next-PC, stalls on in/out
// until the I/O handshake completes, and emits a combinational commit strobe.
// Optional feature macro: PC_SEQ_RETIRE_CNT_EN builds a 16-bit retired
// instruction counter; without it retire_cnt is tied to zero.
// The interface instance must be built with the same PC_W as this module.
module pc_sequencer #(
  parameter int              PC_W     = 11,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic              clock,
  input logic              reset,
  pc_sequencer_if.master   bus
);

  localparam logic [5:0] OP_BEQ  = 6'b001010;
  localparam logic [5:0] OP_BNQ  = 6'b001011;
  localparam logic [5:0] OP_J    = 6'b010000;
  localparam logic [5:0] OP_IN   = 6'b001110;
  localparam logic [5:0] OP_OUT  = 6'b001111;
  localparam logic [5:0] OP_HALT = 6'b111001;

  typedef enum logic [1:0] {
    RUN,
    WAIT_IN,
    WAIT_OUT,
    HALT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] branch_target;
  logic [15:0]     branch_sum;
  logic [5:0]      opcode;
  logic            commit_raw;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            halted_q;
  logic            unused_inst_bits;

  assign opcode           = bus.inst[31:26];
  assign unused_inst_bits = ^bus.inst[25:16];

  // Offsets are added in 16 bits and then truncated, giving modulo-2^PC_W wrap.
  assign pc_inc        = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign branch_sum    = 16'(pc_q) + bus.inst[15:0];
  assign branch_target = branch_sum[PC_W-1:0];

  // Next-state, next-PC and commit decode; eq and handshakes only matter where used.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    commit_raw = 1'b0;
    case (state)
      RUN: begin
        case (opcode)
          OP_BEQ: begin
            commit_raw = 1'b1;
            pc_next    = bus.eq ? branch_target : pc_inc;
          end
          OP_BNQ: begin
            commit_raw = 1'b1;
            pc_next    = bus.eq ? pc_inc : branch_target;
          end
          OP_J: begin
            commit_raw = 1'b1;
            pc_next    = bus.inst[PC_W-1:0];
          end
          OP_IN: begin
            state_next = WAIT_IN;
          end
          OP_OUT: begin
            state_next = WAIT_OUT;
          end
          OP_HALT: begin
            commit_raw = 1'b1;
            state_next = HALT;
          end
          default: begin
            commit_raw = 1'b1;
            pc_next    = pc_inc;
          end
        endcase
      end
      WAIT_IN: begin
        if (bus.in_valid) begin
          commit_raw = 1'b1;
          pc_next    = pc_inc;
          state_next = RUN;
        end
      end
      WAIT_OUT: begin
        if (bus.out_ready) begin
          commit_raw = 1'b1;
          pc_next    = pc_inc;
          state_next = RUN;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State/PC register; handshake flags are registered copies of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state       <= state_next;
      pc_q        <= pc_next;
      in_ready_q  <= (state_next == WAIT_IN);
      out_valid_q <= (state_next == WAIT_OUT);
      halted_q    <= (state_next == HALT);
    end
  end

  assign bus.pc        = pc_q;
  assign bus.commit    = commit_raw & ~reset;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.halted    = halted_q;

`ifdef PC_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_q;

  // Count every retiring cycle; wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_q <= 16'd0;
    end else if (bus.commit) begin
      retire_q <= retire_q + 16'd1;
    end
  end

  assign bus.retire_cnt = retire_q;
`else
  assign bus.retire_cnt = 16'd0;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and fetch-sequencing stage that sits directly upstream of the instruction ROM in the single-cycle MIPS-style core. It drives the 11-bit `pc` fetch address, receives the 32-bit instruction word fetched from that address, and chooses the next PC: sequential, branch (`beq`/`bnq`), jump or halt. It stalls the core on `in`/`out` instructions until the corresponding I/O handshake completes, and emits a per-cycle `commit` strobe that the datapath uses to gate register-file writes.

## Interface
Parameters:
- `PC_W`, 11: width of the PC and fetch address.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clock` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `inst` in 32: instruction word for the current `pc`, valid in the same cycle.
- `eq` in 1: combinational `rs == rt` result from the register file for the current `inst`.
- `in_valid` in 1: external input word available.
- `out_ready` in 1: external sink can accept the output word.
- `pc` out `PC_W`: registered fetch address.
- `commit` out 1: current instruction retires this cycle (combinational).
- `in_ready` out 1: registered; the core is waiting to consume input.
- `out_valid` out 1: registered; the core is presenting output.
- `halted` out 1: registered; the core is stopped.
- `retire_cnt` out 16: retired-instruction count (see Configuration).

## Operation
- Opcode is `inst[31:26]`. Decoded classes:
  - `001010` is beq.
  - `001011` is bnq.
  - `010000` is j.
  - `001110` is in.
  - `001111` is out.
  - `111001` is halt.
  - Every other opcode, including unknown ones, is sequential.
- FSM states are RUN, WAIT_IN, WAIT_OUT and HALT. The reset state is RUN.
- In RUN, the instruction class selects the action:
  - Sequential: `pc <= pc+1` and `commit=1`.
  - beq: if `eq`, `pc <= pc + sext(inst[15:0])`, otherwise `pc+1`. `commit=1`.
  - bnq: if `!eq`, `pc <= pc + sext(inst[15:0])`, otherwise `pc+1`. `commit=1`.
  - Branch targets are relative to the branch's own PC, not PC+1.
  - j: `pc <= inst[PC_W-1:0]` and `commit=1`.
  - in: `commit=0`, PC holds, go to WAIT_IN, `in_ready <= 1`.
  - out: `commit=0`, PC holds, go to WAIT_OUT, `out_valid <= 1`.
  - halt: `commit=1`, PC holds, go to HALT, `halted <= 1`.
- WAIT_IN: PC holds and `commit=0` until `in_valid`. In the cycle `in_valid=1`:
  - `commit=1` and `pc <= pc+1`.
  - `in_ready <= 0` and state returns to RUN.
  - The datapath captures input data in that cycle.
- WAIT_OUT behaves the same way, using `out_ready` as the completion condition and `out_valid <= 0` on exit.
- HALT: PC, `commit=0` and `halted=1` are held until `reset`. All inputs are ignored.
- Arithmetic:
  - The offset is sign-extended to 16 bits and added in 16 bits.
  - The result is truncated to `PC_W` bits, so wrap-around is modulo 2^PC_W.
  - `pc+1` from 2047 wraps to 0.
- `eq` is sampled only for branch classes in RUN. It is ignored in all other cases.

## Timing
- Reset values: `pc=RESET_PC`, state RUN, `in_ready=0`, `out_valid=0`, `halted=0`, `retire_cnt=0`. `commit` is combinational and is 0 while `reset=1`.
- Reset has priority over every other event, including completion of a pending handshake in the same cycle. Reset in the middle of WAIT_IN or WAIT_OUT abandons the transfer; no commit occurs.
- Latency by instruction class:
  - Non-I/O: one cycle per instruction, with the new `pc` visible the cycle after `commit`.
  - in/out: at least 2 cycles. Cycle 0 decodes; from cycle 1 onward the stage waits for the handshake.
  - If `in_valid` is already high in cycle 1, the transfer completes in cycle 1.
- `in_valid` or `out_ready` asserted while in RUN has no effect; no early completion occurs.
- `in_ready` and `out_valid` are never high at the same time. `halted=1` implies both are 0.

## Configuration
- `PC_SEQ_RETIRE_CNT_EN`:
  - Defined: `retire_cnt` is a 16-bit register that increments on every cycle with `commit=1`, wraps 65535 to 0, and is cleared by `reset`.
  - Undefined: `retire_cnt` is tied to 0 and no counter is built.
- Next-PC and FSM behaviour are identical in both builds.

## Test plan
- Straight-line execution: release reset with 4 sequential opcodes → `pc` = 0, 1, 2, 3, 4 on successive cycles with `commit=1`. With the macro defined, `retire_cnt=4`.
- Branches:
  - beq at pc=8, imm=2, `eq=1` → next `pc=10`. With `eq=0` → next `pc=9`.
  - bnq at pc=9, imm=0xFFFB, `eq=0` → next `pc=4`.
- Jump and wrap:
  - j with `inst[10:0]=1` → next `pc=1`.
  - Sequential opcode at pc=2047 → next `pc=0`.
  - bnq at pc=0, imm=-1, `eq=0` → next `pc=2047`.
- in handshake: in at pc=0 → `in_ready=1` from cycle 1. Hold `in_valid=0` for 3 cycles, so `pc` stays 0 and `commit=0`. Assert `in_valid` → `commit=1` in that cycle, then `pc=1` and `in_ready=0`.
- out handshake with reset during the wait: out at pc=5, `out_ready=0`, then `reset=1` → next cycle `pc=0`, `out_valid=0`, no commit.
- Halt: halt at pc=11 → `commit=1` once, then `halted=1` and `pc=11` held for 10 cycles regardless of `in_valid`/`out_ready`/`eq`. `reset` → `pc=0`, `halted=0`.
